rtc3w_burst_module: RTL and testbench
=====================================

RTC3W_BURST_MODULE -- requirements
Module: rtc3w_burst_module

Interface
REQ-001 Parameter HALF_DIV, default 4: clk cycles per SCLK half-period; legal range 2..255.
REQ-002 Parameter MAX_BURST, default 31: maximum data bytes per transaction; legal range 1..63.
REQ-003 clk  input  1  system clock; all logic on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start_sig  input  2  command: 2'b10 write, 2'b01 read; 2'b00 and 2'b11 mean no operation.
REQ-006 addr  input  8  command byte; bit0 is overridden by the block.
REQ-007 burst_len  input  6  data bytes requested for the transaction.
REQ-008 wr_data  input  8  write byte; sampled when wr_req is asserted.
REQ-009 wr_req  output  1  one-cycle pulse; wr_data latched this cycle, host presents the next byte.
REQ-010 rd_data  output  8  last received byte.
REQ-011 rd_valid  output  1  one-cycle pulse; rd_data is new this cycle.
REQ-012 busy  output  1  high from leaving IDLE until DONE, inclusive.
REQ-013 done_sig  output  1  one-cycle pulse at transaction end.
REQ-014 rtc_rst, rtc_sclk  output  1 each  chip enable and serial clock.
REQ-015 rtc_sio  inout  1  bidirectional data; driven only while sio_oe=1, else high-Z.
REQ-016 sio_oe  output  1  debug: SIO output enable.
REQ-017 bit_cnt  output  9  debug: index of the current bit within the transaction.

Function
REQ-018 FSM states and order: IDLE -> SETUP -> CMD -> DATA -> HOLD -> GAP -> DONE -> IDLE.
REQ-019 IDLE: when start_sig is 10 or 01, latch the operation, addr and the effective length, then enter SETUP on the next edge.
REQ-020 Effective length: N = 1 if burst_len=0; N = MAX_BURST if burst_len>MAX_BURST; otherwise N = burst_len.
REQ-021 Transmitted command byte = {addr[7:1], 1} for read and {addr[7:1], 0} for write; bits sent LSB first.
REQ-022 SETUP: rtc_rst=1, rtc_sclk=0 for HALF_DIV cycles.
REQ-023 Bit cell: SCLK low for HALF_DIV cycles, then high for HALF_DIV cycles (2*HALF_DIV cycles per bit).
REQ-024 Output bits: rtc_sio updates on the first cycle of the low phase and is held through the high phase.
REQ-025 CMD: 8 bit cells with sio_oe=1.
REQ-026 DATA: 8*N bit cells, LSB first per byte.
REQ-027 Write DATA: wr_req pulses on the first cycle of each byte; wr_data is captured in that same cycle.
REQ-028 Read DATA: sio_oe=0 from the first cycle of the first data bit.
REQ-029 Read sampling: rtc_sio is sampled on the last cycle of each low phase.
REQ-030 Read completion: after the 8th sample of a byte, rd_data is loaded and rd_valid pulses on the next cycle.
REQ-031 HOLD: after the final high phase, rtc_sclk=0 and rtc_rst=1 for HALF_DIV cycles.
REQ-032 GAP: rtc_rst=0 and sio_oe=0 for 2*HALF_DIV cycles.
REQ-033 DONE: done_sig=1 and busy=1 for one cycle, then IDLE.
REQ-034 If start_sig is still active in IDLE after DONE, a new transaction starts; the host clears start_sig on done_sig.
REQ-035 start_sig changes while busy are ignored; addr, burst_len and operation are frozen at latch.
REQ-036 start_sig=11 in IDLE: stay in IDLE, no output activity.

Reset
REQ-037 rst_n low at any time, including mid-transaction, forces IDLE within the same cycle.
REQ-038 Reset values: rtc_rst=0, rtc_sclk=0, sio_oe=0 (SIO high-Z), busy=0, done_sig=0, wr_req=0, rd_valid=0, rd_data=8'h00, bit_cnt=0.
REQ-039 No SCLK edge is generated after reset until a new start.

Configuration
REQ-040 Macro RTC3W_BURST_EN defined: behaviour exactly as REQ-020 through REQ-030.
REQ-041 Macro RTC3W_BURST_EN undefined: burst_len is ignored, N=1 always, and the byte counter is not synthesised.

Verification
REQ-042 HALF_DIV=4: write, addr=8'h80, N=1, wr_data=8'hF2 -> SIO bit stream 0,0,0,0,0,0,0,1 then 0,1,0,0,1,1,1,1; 16 SCLK pulses; done_sig after exactly 4+128+4+8+1 cycles from SETUP entry.
REQ-043 Read, addr=8'h81, N=1, bench drives 8'h55 during the data phase -> command LSB=1; sio_oe=0 during data; rd_data=8'h55 with one rd_valid pulse.
REQ-044 Burst write, addr=8'hFE, burst_len=3, data 11/22/33 -> 3 wr_req pulses, 32 SCLK pulses, bytes emitted in order.
REQ-045 Burst read with burst_len=40, MAX_BURST=31 -> 31 rd_valid pulses; burst_len=0 -> 1 rd_valid pulse.
REQ-046 rst_n asserted during the 5th CMD bit -> rtc_rst=0 and SIO high-Z immediately, busy=0, no done_sig; the next start completes normally.
REQ-047 With RTC3W_BURST_EN undefined, burst_len=5 -> single byte transferred, 16 SCLK pulses.

Source files
------------

// File: rtl/rtc3w_burst_module.sv
// rtc3w_burst_module - 3-wire serial RTC master with optional burst transfers.
//
// Shifts a command byte {addr[7:1], rd} out LSB first, then moves N data
// bytes (write: out of wr_data, read: in from rtc_sio). Each bit cell is
// HALF_DIV clk cycles of SCLK low followed by HALF_DIV cycles of SCLK high.
// Transaction order: IDLE -> SETUP -> CMD -> DATA -> HOLD -> GAP -> DONE.
//
// Configuration macro: RTC3W_BURST_EN
//   defined   : N = burst_len clamped to 1..MAX_BURST (0 maps to 1)
//   undefined : burst_len ignored, N = 1, no length register
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start_sig[1:0]       2'b10 write, 2'b01 read, others no-op
//   addr[7:0]            command byte (bit0 replaced by the read flag)
//   burst_len[5:0]       requested data byte count
//   wr_data[7:0]         write byte, taken when wr_req pulses
//   wr_req               one-cycle pulse per write byte
//   rd_data[7:0]         last received byte
//   rd_valid             one-cycle pulse, rd_data is new
//   busy                 high from SETUP through DONE
//   done_sig             one-cycle pulse in DONE
//   rtc_rst, rtc_sclk    chip enable and serial clock
//   rtc_sio              bidirectional data, driven only while sio_oe=1
//   sio_oe               SIO output enable (debug)
//   bit_cnt[8:0]         current bit index within the transaction (debug)
module rtc3w_burst_module #(
    parameter int HALF_DIV  = 4,
    parameter int MAX_BURST = 31
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] start_sig,
    input  logic [7:0] addr,
    input  logic [5:0] burst_len,
    input  logic [7:0] wr_data,
    output logic       wr_req,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       done_sig,
    output logic       rtc_rst,
    output logic       rtc_sclk,
    inout  wire        rtc_sio,
    output logic       sio_oe,
    output logic [8:0] bit_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        CMD   = 3'd2,
        DATA  = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam logic [8:0] HD_LAST  = 9'(HALF_DIV - 1);
    localparam logic [8:0] GAP_LAST = 9'(2 * HALF_DIV - 1);

    state_t     state_r, state_s;
    logic [8:0] div_r, div_s;
    logic       high_r, high_s;
    logic [8:0] bit_r, bit_s;
    logic [7:0] sh_r, sh_s;
    logic       rd_op_r, rd_op_s;
    logic       sio_out_r, sio_out_s;
    logic       sio_oe_r, sio_oe_s;
    logic       sclk_r, sclk_s;
    logic       ce_r, ce_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;
    logic       wr_req_r, wr_req_s;
    logic       rd_valid_r, rd_valid_s;
    logic [7:0] rd_data_r, rd_data_s;
    logic [8:0] last_bit_s;
    logic       phase_end_s;
    logic       unused_s;

`ifdef RTC3W_BURST_EN
    logic [5:0] len_r, len_s;

    // Clamp the requested length into 1..MAX_BURST.
    function automatic logic [5:0] eff_len(input logic [5:0] req);
        logic [5:0] n;
        if (req == 6'd0) begin
            n = 6'd1;
        end else if (req > 6'(MAX_BURST)) begin
            n = 6'(MAX_BURST);
        end else begin
            n = req;
        end
        return n;
    endfunction

    // Index of the final data bit is 8*N+7.
    assign last_bit_s = {len_r, 3'b111};
    assign unused_s   = addr[0];
`else
    assign last_bit_s = 9'd15;
    assign unused_s   = ^{addr[0], burst_len};
`endif

    assign phase_end_s = (div_r == HD_LAST);

    assign rtc_sio  = sio_oe_r ? sio_out_r : 1'bz;
    assign wr_req   = wr_req_r;
    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign busy     = busy_r;
    assign done_sig = done_r;
    assign rtc_rst  = ce_r;
    assign rtc_sclk = sclk_r;
    assign sio_oe   = sio_oe_r;
    assign bit_cnt  = bit_r;

    // Next-state and next-output logic; outputs are registered so they line up with state_r.
    always_comb begin
        state_s    = state_r;
        div_s      = div_r + 9'd1;
        high_s     = high_r;
        bit_s      = bit_r;
        sh_s       = sh_r;
        rd_op_s    = rd_op_r;
        sio_out_s  = sio_out_r;
        sio_oe_s   = sio_oe_r;
        sclk_s     = sclk_r;
        ce_s       = ce_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        wr_req_s   = 1'b0;
        rd_valid_s = 1'b0;
        rd_data_s  = rd_data_r;
`ifdef RTC3W_BURST_EN
        len_s      = len_r;
`endif
        case (state_r)
            IDLE: begin
                div_s     = 9'd0;
                high_s    = 1'b0;
                bit_s     = 9'd0;
                sclk_s    = 1'b0;
                ce_s      = 1'b0;
                sio_oe_s  = 1'b0;
                sio_out_s = 1'b0;
                busy_s    = 1'b0;
                if (start_sig == 2'b10 || start_sig == 2'b01) begin
                    rd_op_s = start_sig[0];
                    sh_s    = {addr[7:1], start_sig[0]};
`ifdef RTC3W_BURST_EN
                    len_s   = eff_len(burst_len);
`endif
                    ce_s    = 1'b1;
                    busy_s  = 1'b1;
                    state_s = SETUP;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                if (phase_end_s) begin
                    state_s   = CMD;
                    div_s     = 9'd0;
                    sio_oe_s  = 1'b1;
                    sio_out_s = sh_r[0];
                end else begin
                    state_s = SETUP;
                end
            end
            CMD, DATA: begin
                if (!high_r) begin
                    // Read data is sampled on the last low-phase cycle.
                    if (state_r == DATA && rd_op_r && phase_end_s) begin
                        sh_s = {rtc_sio, sh_r[7:1]};
                        if (bit_r[2:0] == 3'd7) begin
                            rd_data_s  = {rtc_sio, sh_r[7:1]};
                            rd_valid_s = 1'b1;
                        end else begin
                            rd_valid_s = 1'b0;
                        end
                    end else begin
                        sh_s = sh_r;
                    end
                    if (phase_end_s) begin
                        high_s = 1'b1;
                        div_s  = 9'd0;
                        sclk_s = 1'b1;
                    end else begin
                        high_s = 1'b0;
                    end
                end else if (phase_end_s) begin
                    sclk_s = 1'b0;
                    high_s = 1'b0;
                    div_s  = 9'd0;
                    if (bit_r == last_bit_s) begin
                        state_s = HOLD;
                    end else begin
                        bit_s = bit_r + 9'd1;
                        if (bit_r[2:0] == 3'd7) begin
                            // Byte boundary: the next cell starts a data byte.
                            state_s = DATA;
                            if (rd_op_r) begin
                                sio_oe_s = 1'b0;
                            end else begin
                                wr_req_s  = 1'b1;
                                sh_s      = wr_data;
                                sio_out_s = wr_data[0];
                            end
                        end else if (state_r == CMD || !rd_op_r) begin
                            sh_s      = {1'b0, sh_r[7:1]};
                            sio_out_s = sh_r[1];
                        end else begin
                            sh_s = sh_r;
                        end
                    end
                end else begin
                    high_s = high_r;
                end
            end
            HOLD: begin
                if (phase_end_s) begin
                    state_s  = GAP;
                    div_s    = 9'd0;
                    ce_s     = 1'b0;
                    sio_oe_s = 1'b0;
                end else begin
                    state_s = HOLD;
                end
            end
            GAP: begin
                if (div_r == GAP_LAST) begin
                    state_s = DONE;
                    div_s   = 9'd0;
                    done_s  = 1'b1;
                end else begin
                    state_s = GAP;
                end
            end
            DONE: begin
                state_s = IDLE;
                div_s   = 9'd0;
                busy_s  = 1'b0;
            end
            default: begin
                state_s  = IDLE;
                div_s    = 9'd0;
                busy_s   = 1'b0;
                ce_s     = 1'b0;
                sclk_s   = 1'b0;
                sio_oe_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops the bus to idle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            div_r      <= 9'd0;
            high_r     <= 1'b0;
            bit_r      <= 9'd0;
            sh_r       <= 8'h00;
            rd_op_r    <= 1'b0;
            sio_out_r  <= 1'b0;
            sio_oe_r   <= 1'b0;
            sclk_r     <= 1'b0;
            ce_r       <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            wr_req_r   <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= 8'h00;
`ifdef RTC3W_BURST_EN
            len_r      <= 6'd1;
`endif
        end else begin
            state_r    <= state_s;
            div_r      <= div_s;
            high_r     <= high_s;
            bit_r      <= bit_s;
            sh_r       <= sh_s;
            rd_op_r    <= rd_op_s;
            sio_out_r  <= sio_out_s;
            sio_oe_r   <= sio_oe_s;
            sclk_r     <= sclk_s;
            ce_r       <= ce_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            wr_req_r   <= wr_req_s;
            rd_valid_r <= rd_valid_s;
            rd_data_r  <= rd_data_s;
`ifdef RTC3W_BURST_EN
            len_r      <= len_s;
`endif
        end
    end

endmodule

// File: tb/tb_rtc3w_burst_module.sv
// Self-checking bench for rtc3w_burst_module (HALF_DIV=4, MAX_BURST=31).
// A vector table drives whole transactions; a scoreboard holds the bytes
// expected on SIO (command + write data) and on rd_data, popped as the DUT
// produces them. Hand-written sequences cover mid-transaction reset,
// start_sig=11 and back-to-back starts.
module tb_rtc3w_burst_module;

    localparam int HD = 4;
    localparam int MB = 31;
`ifdef RTC3W_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    typedef struct {
        logic [1:0] op;
        logic [7:0] addr;
        logic [5:0] blen;
        logic [7:0] seed;
        int         exp_n;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] start_sig;
    logic [7:0] addr;
    logic [5:0] burst_len;
    logic [7:0] wr_data;
    logic       wr_req;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       done_sig;
    logic       rtc_rst;
    logic       rtc_sclk;
    logic       sio_oe;
    logic [8:0] bit_cnt;
    wire        rtc_sio;

    logic       rd_mode;
    logic       tb_bit;
    logic [7:0] rd_seed;
    logic [7:0] wr_seed;
    int         rises;
    int         rise_base;

    int         n_cmp;
    int         n_bad;
    int         busy_cnt, done_cnt, wr_cnt, rd_cnt, tx_bits, wr_idx;
    logic       prev_sclk;
    logic [7:0] tx_byte;
    bit         sb_en;
    bit         wr_pend;
    logic [7:0] tx_q[$];
    logic [7:0] rd_q[$];
    vec_t       vecs[7];

    rtc3w_burst_module #(.HALF_DIV(HD), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_sig (start_sig),
        .addr      (addr),
        .burst_len (burst_len),
        .wr_data   (wr_data),
        .wr_req    (wr_req),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .busy      (busy),
        .done_sig  (done_sig),
        .rtc_rst   (rtc_rst),
        .rtc_sclk  (rtc_sclk),
        .rtc_sio   (rtc_sio),
        .sio_oe    (sio_oe),
        .bit_cnt   (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rd_pat(input logic [7:0] seed, input int j);
        return seed + 8'(j * 59);
    endfunction

    function automatic logic [7:0] wr_pat(input logic [7:0] seed, input int j);
        return seed + 8'(j * 17);
    endfunction

    function automatic logic pat_bit(input logic [7:0] seed, input int k);
        logic [7:0] b;
        if (k < 0) return 1'b0;
        b = rd_pat(seed, k / 8);
        return b[k % 8];
    endfunction

    // Slave model: presents data bit k once 8+k SCLK rises have been seen.
    assign tb_bit  = pat_bit(rd_seed, rises - rise_base - 8);
    assign rtc_sio = (rd_mode && !sio_oe) ? tb_bit : 1'bz;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: sample at negedge, update monitors and scoreboard.
    task automatic step();
        logic [7:0] e;
        @(negedge clk);
        if (busy) busy_cnt++;
        if (done_sig) done_cnt++;
        if (wr_pend) begin
            wr_data = wr_pat(wr_seed, wr_idx);
            wr_idx++;
        end
        wr_pend = wr_req;
        if (wr_req) wr_cnt++;
        if (rd_valid) begin
            rd_cnt++;
            if (sb_en) begin
                check("rd_q_nonempty", int'(rd_q.size() > 0), 1);
                if (rd_q.size() > 0) begin
                    e = rd_q.pop_front();
                    check("rd_data", int'(rd_data), int'(e));
                end
            end
        end
        if (rtc_sclk && !prev_sclk) begin
            rises++;
            if (sio_oe) begin
                tx_byte = {rtc_sio, tx_byte[7:1]};
                tx_bits++;
                if (tx_bits % 8 == 0 && sb_en) begin
                    check("tx_q_nonempty", int'(tx_q.size() > 0), 1);
                    if (tx_q.size() > 0) begin
                        e = tx_q.pop_front();
                        check("tx_byte", int'(tx_byte), int'(e));
                    end
                end
            end
        end
        prev_sclk = rtc_sclk;
    endtask

    task automatic clear_counts();
        busy_cnt  = 0;
        done_cnt  = 0;
        wr_cnt    = 0;
        rd_cnt    = 0;
        tx_bits   = 0;
        rise_base = rises;
    endtask

    task automatic run_vec(input vec_t v);
        bit is_rd;
        int n;
        int cyc;
        n     = v.exp_n;
        is_rd = (v.op == 2'b01);
        sb_en = 1'b1;
        tx_q.delete();
        rd_q.delete();
        clear_counts();
        tx_q.push_back({v.addr[7:1], is_rd});
        for (int j = 0; j < n; j++) begin
            if (is_rd) rd_q.push_back(rd_pat(v.seed, j));
            else       tx_q.push_back(wr_pat(v.seed, j));
        end
        rd_mode   = is_rd;
        rd_seed   = v.seed;
        wr_seed   = v.seed;
        wr_data   = wr_pat(v.seed, 0);
        wr_idx    = 1;
        wr_pend   = 1'b0;
        addr      = v.addr;
        burst_len = v.blen;
        start_sig = v.op;
        cyc = 0;
        while (done_cnt == 0 && cyc < 5000) begin
            step();
            cyc++;
            if (cyc == 10) begin
                // Changes while busy must not affect the running transaction.
                addr      = ~v.addr;
                burst_len = 6'd63;
                start_sig = ~v.op;
            end
        end
        start_sig = 2'b00;
        for (int i = 0; i < 4; i++) step();
        check("done_pulses", done_cnt, 1);
        check("busy_cycles", busy_cnt, HD * (20 + 16 * n) + 1);
        check("sclk_pulses", rises - rise_base, 8 + 8 * n);
        check("wr_req_pulses", wr_cnt, is_rd ? 0 : n);
        check("rd_valid_pulses", rd_cnt, is_rd ? n : 0);
        check("driven_bits", tx_bits, is_rd ? 8 : 8 + 8 * n);
        check("sb_left", tx_q.size() + rd_q.size(), 0);
        check("busy_after", int'(busy), 0);
        rd_mode = 1'b0;
    endtask

    initial begin
        int cyc;
        n_cmp     = 0;
        n_bad     = 0;
        rises     = 0;
        rise_base = 0;
        prev_sclk = 1'b0;
        tx_byte   = 8'h00;
        sb_en     = 1'b0;
        wr_pend   = 1'b0;
        wr_idx    = 0;
        rd_mode   = 1'b0;
        rd_seed   = 8'h00;
        wr_seed   = 8'h00;
        rst_n     = 1'b0;
        start_sig = 2'b00;
        addr      = 8'h00;
        burst_len = 6'd0;
        wr_data   = 8'h00;
        clear_counts();

        vecs[0] = '{2'b10, 8'h80, 6'd1,  8'hF2, 1};
        vecs[1] = '{2'b01, 8'h81, 6'd1,  8'h55, 1};
        vecs[2] = '{2'b10, 8'hFE, 6'd3,  8'h11, BURST ? 3 : 1};
        vecs[3] = '{2'b01, 8'h40, 6'd40, 8'h9A, BURST ? MB : 1};
        vecs[4] = '{2'b01, 8'h81, 6'd0,  8'hC3, 1};
        vecs[5] = '{2'b10, 8'h81, 6'd5,  8'h07, BURST ? 5 : 1};
        vecs[6] = '{2'b01, 8'h2C, 6'd31, 8'h66, BURST ? 31 : 1};

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_rtc_rst", int'(rtc_rst), 0);
        check("rst_sclk", int'(rtc_sclk), 0);
        check("rst_oe", int'(sio_oe), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done_sig), 0);
        check("rst_wr_req", int'(wr_req), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_bit_cnt", int'(bit_cnt), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();

        for (int v = 0; v < 7; v++) run_vec(vecs[v]);

        // Reset asserted during the 5th command bit.
        sb_en     = 1'b0;
        clear_counts();
        addr      = 8'hA4;
        burst_len = 6'd1;
        wr_data   = 8'h3C;
        start_sig = 2'b10;
        cyc = 0;
        while (rises - rise_base < 4 && cyc < 500) begin
            step();
            cyc++;
        end
        for (int i = 0; i < HD + 1; i++) step();
        check("pre_rst_bit_cnt", int'(bit_cnt), 4);
        check("pre_rst_ce", int'(rtc_rst), 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_ce", int'(rtc_rst), 0);
        check("mid_rst_oe", int'(sio_oe), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_bit_cnt", int'(bit_cnt), 0);
        start_sig = 2'b00;
        for (int i = 0; i < 5; i++) step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("mid_rst_no_done", done_cnt, 0);
        check("mid_rst_no_sclk", rises - rise_base, 4);

        // start_sig=11 is a no-op.
        clear_counts();
        start_sig = 2'b11;
        for (int i = 0; i < 20; i++) step();
        start_sig = 2'b00;
        check("nop_busy", busy_cnt, 0);
        check("nop_sclk", rises - rise_base, 0);
        check("nop_ce", int'(rtc_rst), 0);

        // Next start after reset completes normally.
        run_vec(vecs[0]);

        // start_sig left active after DONE begins a new transaction.
        sb_en     = 1'b0;
        clear_counts();
        wr_seed   = 8'h40;
        wr_idx    = 1;
        addr      = 8'h90;
        burst_len = 6'd1;
        start_sig = 2'b10;
        cyc = 0;
        while (done_cnt == 0 && cyc < 2000) begin
            step();
            cyc++;
        end
        step();
        step();
        check("b2b_restart", int'(busy), 1);
        start_sig = 2'b00;
        cyc = 0;
        while (done_cnt < 2 && cyc < 2000) begin
            step();
            cyc++;
        end
        check("b2b_done_count", done_cnt, 2);
        for (int i = 0; i < 4; i++) step();
        check("b2b_idle", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
